// File: rtl/systolic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_pkg: shared constants, sequencer state type and helpers   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package systolic_pkg;

  localparam int TILE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_TILE = 2'd2,
    FINISH    = 2'd3
  } seq_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2_ceil_div(input int a, input int b);
    return $clog2(ceil_div(a, b));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_index_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tile_index_counter: nested r/k/tn/tm walk with running addr bases  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tile_index_counter
  import systolic_pkg::*;
#(
  parameter int M_SIZE     = 12,
  parameter int N_SIZE     = 12,
  parameter int K_SIZE     = 16,
  parameter int TILE       = TILE_DEFAULT,
  parameter int ADDR_WIDTH = 16,
  parameter int TMW        = clog2_ceil_div(M_SIZE, TILE) + 1,
  parameter int TNW        = clog2_ceil_div(N_SIZE, TILE) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  step_beat,
  input  logic                  step_tile,
  output logic [TMW-1:0]        tm,
  output logic [TNW-1:0]        tn,
  output logic                  first_beat,
  output logic                  last_beat,
  output logic                  last_tile,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  a_pad,
  output logic                  b_pad
);

  localparam int TM = ceil_div(M_SIZE, TILE);
  localparam int TN = ceil_div(N_SIZE, TILE);
  localparam int RW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int KW = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;

  logic [RW-1:0]         r_r;
  logic [KW-1:0]         r_k;
  logic [TNW-1:0]        r_tn;
  logic [TMW-1:0]        r_tm;
  // Bases: r_row_base = tm*TILE, r_col_base = tn*TILE, r_a_tile = tm*TILE*K,
  // r_a_off = r*K, r_b_k = k*N.
  logic [ADDR_WIDTH-1:0] r_row_base, r_col_base, r_a_tile, r_a_off, r_b_k;

  logic                  w_r_wrap, w_k_wrap, w_tn_wrap, w_tm_wrap;
  logic [ADDR_WIDTH-1:0] w_row, w_col;

  assign w_r_wrap  = (r_r == RW'(TILE - 1));
  assign w_k_wrap  = (r_k == KW'(K_SIZE - 1));
  assign w_tn_wrap = (r_tn == TNW'(TN - 1));
  assign w_tm_wrap = (r_tm == TMW'(TM - 1));

  assign w_row = r_row_base + ADDR_WIDTH'(r_r);
  assign w_col = r_col_base + ADDR_WIDTH'(r_r);

  assign a_pad  = (w_row >= ADDR_WIDTH'(M_SIZE));
  assign b_pad  = (w_col >= ADDR_WIDTH'(N_SIZE));
  assign a_addr = a_pad ? '0 : (r_a_tile + r_a_off + ADDR_WIDTH'(r_k));
  assign b_addr = b_pad ? '0 : (r_b_k + w_col);

  assign tm         = r_tm;
  assign tn         = r_tn;
  assign first_beat = (r_r == '0) && (r_k == '0);
  assign last_beat  = w_r_wrap && w_k_wrap;
  assign last_tile  = w_tn_wrap && w_tm_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= '0; r_k <= '0; r_tn <= '0; r_tm <= '0;
      r_row_base <= '0; r_col_base <= '0; r_a_tile <= '0; r_a_off <= '0; r_b_k <= '0;
    end else if (clear) begin
      r_r <= '0; r_k <= '0; r_tn <= '0; r_tm <= '0;
      r_row_base <= '0; r_col_base <= '0; r_a_tile <= '0; r_a_off <= '0; r_b_k <= '0;
    end else if (step_beat) begin
      // The final beat of a tile wraps r and k back to 0 ready for the next tile.
      if (w_r_wrap) begin
        r_r     <= '0;
        r_a_off <= '0;
        if (w_k_wrap) begin
          r_k   <= '0;
          r_b_k <= '0;
        end else begin
          r_k   <= r_k + 1'b1;
          r_b_k <= r_b_k + ADDR_WIDTH'(N_SIZE);
        end
      end else begin
        r_r     <= r_r + 1'b1;
        r_a_off <= r_a_off + ADDR_WIDTH'(K_SIZE);
      end
    end else if (step_tile) begin
      if (w_tn_wrap) begin
        r_tn       <= '0;
        r_col_base <= '0;
        r_tm       <= r_tm + 1'b1;
        r_row_base <= r_row_base + ADDR_WIDTH'(TILE);
        r_a_tile   <= r_a_tile + ADDR_WIDTH'(TILE * K_SIZE);
      end else begin
        r_tn       <= r_tn + 1'b1;
        r_col_base <= r_col_base + ADDR_WIDTH'(TILE);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tile_operand_sequencer: lockstep A/B operand address stream        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tile_operand_sequencer
  import systolic_pkg::*;
#(
  parameter int M_SIZE     = 12,
  parameter int N_SIZE     = 12,
  parameter int K_SIZE     = 16,
  parameter int TILE       = TILE_DEFAULT,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 out_ready,
  input  logic                                 tile_done,
  output logic [ADDR_WIDTH-1:0]                a_addr,
  output logic [ADDR_WIDTH-1:0]                b_addr,
  output logic                                 a_pad,
  output logic                                 b_pad,
  output logic                                 out_valid,
  output logic                                 tile_first,
  output logic                                 tile_last,
  output logic [clog2_ceil_div(M_SIZE, TILE):0] tile_row,
  output logic [clog2_ceil_div(N_SIZE, TILE):0] tile_col,
  output logic                                 busy,
  output logic                                 done
);

  localparam int TMW = clog2_ceil_div(M_SIZE, TILE) + 1;
  localparam int TNW = clog2_ceil_div(N_SIZE, TILE) + 1;

  localparam longint A_SPAN   = longint'(M_SIZE) * longint'(K_SIZE);
  localparam longint B_SPAN   = longint'(K_SIZE) * longint'(N_SIZE);
  localparam longint ADDR_CAP = longint'(1) << ADDR_WIDTH;

  generate
    if (TILE < 1) begin : g_bad_tile
      $error("TILE must be at least 1");
    end
    if (K_SIZE < 1) begin : g_bad_k
      $error("K_SIZE must be at least 1");
    end
    if ((A_SPAN > ADDR_CAP) || (B_SPAN > ADDR_CAP)) begin : g_bad_addr
      $error("ADDR_WIDTH too narrow for operand matrices");
    end
  endgenerate

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_STREAM = STREAM;
  localparam logic [1:0] S_WAIT   = WAIT_TILE;
  localparam logic [1:0] S_FINISH = FINISH;

  logic [1:0]            r_state;
  logic                  w_clear, w_step_beat, w_step_tile;
  logic                  w_first_beat, w_last_beat, w_last_tile, w_a_pad, w_b_pad;
  logic [ADDR_WIDTH-1:0] w_a_addr, w_b_addr;
  logic [TMW-1:0]        w_tm;
  logic [TNW-1:0]        w_tn;

  // abort outranks every other request; the counter honours clear first.
  assign w_clear     = abort || ((r_state == S_IDLE) && start) || (r_state == S_FINISH);
  assign w_step_beat = (r_state == S_STREAM) && out_ready;
  assign w_step_tile = (r_state == S_WAIT) && tile_done && !w_last_tile;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_STREAM;
        S_STREAM: if (out_ready && w_last_beat) r_state <= S_WAIT;
        S_WAIT:   if (tile_done) r_state <= w_last_tile ? S_FINISH : S_STREAM;
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  tile_index_counter #(
    .M_SIZE     (M_SIZE),
    .N_SIZE     (N_SIZE),
    .K_SIZE     (K_SIZE),
    .TILE       (TILE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TMW        (TMW),
    .TNW        (TNW)
  ) u_index (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_clear),
    .step_beat  (w_step_beat),
    .step_tile  (w_step_tile),
    .tm         (w_tm),
    .tn         (w_tn),
    .first_beat (w_first_beat),
    .last_beat  (w_last_beat),
    .last_tile  (w_last_tile),
    .a_addr     (w_a_addr),
    .b_addr     (w_b_addr),
    .a_pad      (w_a_pad),
    .b_pad      (w_b_pad)
  );

  assign out_valid  = (r_state == S_STREAM);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);
  assign a_addr     = out_valid ? w_a_addr : '0;
  assign b_addr     = out_valid ? w_b_addr : '0;
  assign a_pad      = out_valid && w_a_pad;
  assign b_pad      = out_valid && w_b_pad;
  assign tile_first = out_valid && w_first_beat;
  assign tile_last  = out_valid && w_last_beat;
  assign tile_row   = w_tm;
  assign tile_col   = w_tn;

endmodule
`default_nettype wire

// File: tb/tb_tile_operand_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tile_operand_sequencer: default and ragged instances vs model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tile_operand_sequencer;

  typedef struct {
    int a; int b; int ap; int bp; int first; int last; int tr; int tc;
  } beat_t;

  localparam int P_IDLE = 0, P_STREAM = 1, P_WAIT = 2, P_FIN = 3;

  int cm[2] = '{12, 6};
  int cn[2] = '{12, 6};
  int ck[2] = '{16, 4};
  int ct[2] = '{4, 4};

  beat_t tab[2][576];
  int    len[2];
  int    ph[2];
  int    ptr[2];

  int n_pass = 0, n_tot = 0;
  int beats[2], dones[2], n_ap[2], n_bp[2], n_both[2];
  int td_cnt[2];
  bit rnd[2];
  bit acc_last[2];
  bit prev_stall[2];
  int prev_a[2], prev_b[2], prev_f[2];
  int cyc = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start[2], abort[2], out_ready[2], tile_done[2];
  logic [15:0] a_addr[2], b_addr[2];
  logic a_pad[2], b_pad[2], out_valid[2], tile_first[2], tile_last[2], busy[2], done[2];
  logic [2:0] tr0, tc0;
  logic [1:0] tr1, tc1;

  always #5 clk = ~clk;

  tile_operand_sequencer #(.M_SIZE(12), .N_SIZE(12), .K_SIZE(16), .TILE(4), .ADDR_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .out_ready(out_ready[0]),
    .tile_done(tile_done[0]), .a_addr(a_addr[0]), .b_addr(b_addr[0]), .a_pad(a_pad[0]),
    .b_pad(b_pad[0]), .out_valid(out_valid[0]), .tile_first(tile_first[0]), .tile_last(tile_last[0]),
    .tile_row(tr0), .tile_col(tc0), .busy(busy[0]), .done(done[0]));

  tile_operand_sequencer #(.M_SIZE(6), .N_SIZE(6), .K_SIZE(4), .TILE(4), .ADDR_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .out_ready(out_ready[1]),
    .tile_done(tile_done[1]), .a_addr(a_addr[1]), .b_addr(b_addr[1]), .a_pad(a_pad[1]),
    .b_pad(b_pad[1]), .out_valid(out_valid[1]), .tile_first(tile_first[1]), .tile_last(tile_last[1]),
    .tile_row(tr1), .tile_col(tc1), .busy(busy[1]), .done(done[1]));

  function automatic void chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // Full expected beat list for one pass, straight from the address formulas.
  function automatic void build(int d);
    int m, n, kk, t, tmn, tnn, idx, row, col;
    beat_t e;
    m = cm[d]; n = cn[d]; kk = ck[d]; t = ct[d];
    tmn = (m + t - 1) / t;
    tnn = (n + t - 1) / t;
    idx = 0;
    for (int tm = 0; tm < tmn; tm++)
      for (int tn = 0; tn < tnn; tn++)
        for (int k = 0; k < kk; k++)
          for (int r = 0; r < t; r++) begin
            row = tm * t + r;
            col = tn * t + r;
            e.ap = (row >= m) ? 1 : 0;
            e.bp = (col >= n) ? 1 : 0;
            e.a = e.ap ? 0 : row * kk + k;
            e.b = e.bp ? 0 : k * n + col;
            e.first = (k == 0 && r == 0) ? 1 : 0;
            e.last = (k == kk - 1 && r == t - 1) ? 1 : 0;
            e.tr = tm;
            e.tc = tn;
            tab[d][idx] = e;
            idx++;
          end
    len[d] = idx;
  endfunction

  // Pass-level model: which phase each instance is in and which beat is due.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ph[d] <= P_IDLE; ptr[d] <= 0;
      end else if (abort[d]) begin
        ph[d] <= P_IDLE; ptr[d] <= 0;
      end else begin
        case (ph[d])
          P_IDLE:   if (start[d]) begin ph[d] <= P_STREAM; ptr[d] <= 0; end
          P_STREAM: if (out_ready[d]) begin
                      if (tab[d][ptr[d]].last != 0) ph[d] <= P_WAIT;
                      ptr[d] <= ptr[d] + 1;
                    end
          P_WAIT:   if (tile_done[d]) ph[d] <= (ptr[d] == len[d]) ? P_FIN : P_STREAM;
          default:  ph[d] <= P_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (cyc > 2) begin
      for (int d = 0; d < 2; d++) begin
        int trow, tcol;
        trow = (d == 0) ? int'(tr0) : int'(tr1);
        tcol = (d == 0) ? int'(tc0) : int'(tc1);
        chk($sformatf("d%0d_busy", d), int'(busy[d]), (ph[d] != P_IDLE) ? 1 : 0);
        chk($sformatf("d%0d_valid", d), int'(out_valid[d]), (ph[d] == P_STREAM) ? 1 : 0);
        chk($sformatf("d%0d_done", d), int'(done[d]), (ph[d] == P_FIN) ? 1 : 0);
        if (ph[d] == P_STREAM) begin
          chk($sformatf("d%0d_a_addr[%0d]", d, ptr[d]), int'(a_addr[d]), tab[d][ptr[d]].a);
          chk($sformatf("d%0d_b_addr[%0d]", d, ptr[d]), int'(b_addr[d]), tab[d][ptr[d]].b);
          chk($sformatf("d%0d_a_pad[%0d]", d, ptr[d]), int'(a_pad[d]), tab[d][ptr[d]].ap);
          chk($sformatf("d%0d_b_pad[%0d]", d, ptr[d]), int'(b_pad[d]), tab[d][ptr[d]].bp);
          chk($sformatf("d%0d_first[%0d]", d, ptr[d]), int'(tile_first[d]), tab[d][ptr[d]].first);
          chk($sformatf("d%0d_last[%0d]", d, ptr[d]), int'(tile_last[d]), tab[d][ptr[d]].last);
          chk($sformatf("d%0d_tile_row", d), trow, tab[d][ptr[d]].tr);
          chk($sformatf("d%0d_tile_col", d), tcol, tab[d][ptr[d]].tc);
          if (prev_stall[d]) begin
            chk($sformatf("d%0d_stall_a", d), int'(a_addr[d]), prev_a[d]);
            chk($sformatf("d%0d_stall_b", d), int'(b_addr[d]), prev_b[d]);
            chk($sformatf("d%0d_stall_first", d), int'(tile_first[d]), prev_f[d]);
          end
        end
        prev_stall[d] = out_valid[d] && !out_ready[d];
        prev_a[d] = int'(a_addr[d]);
        prev_b[d] = int'(b_addr[d]);
        prev_f[d] = int'(tile_first[d]);
        if (out_valid[d] && out_ready[d] && !abort[d]) begin
          beats[d]++;
          if (a_pad[d]) n_ap[d]++;
          if (b_pad[d]) n_bp[d]++;
          if (a_pad[d] && b_pad[d]) n_both[d]++;
        end
        if (done[d]) dones[d]++;
      end
    end
  end

  // One clock: note accepted tile_last beats, then drive fresh inputs 1 after the edge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      acc_last[d] = out_valid[d] && out_ready[d] && tile_last[d] && !abort[d];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      abort[d] = 1'b0;
      tile_done[d] = 1'b0;
      out_ready[d] = rnd[d] ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (td_cnt[d] > 0) begin
        td_cnt[d]--;
        if (td_cnt[d] == 0) tile_done[d] = 1'b1;
      end
      if (acc_last[d]) td_cnt[d] = 3;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      beats[d] = 0; dones[d] = 0; n_ap[d] = 0; n_bp[d] = 0; n_both[d] = 0;
    end
  endtask

  task automatic run_to_idle(input string nm, input int budget);
    int i;
    i = 0;
    while ((ph[0] != P_IDLE || ph[1] != P_IDLE) && i < budget) begin
      tick();
      i++;
    end
    if (i >= budget) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_a_addr"}, int'(a_addr[0]), 0);
    chk({nm, "_b_addr"}, int'(b_addr[0]), 0);
    chk({nm, "_pads"}, int'({a_pad[0], b_pad[0]}), 0);
    chk({nm, "_valid"}, int'(out_valid[0]), 0);
    chk({nm, "_first_last"}, int'({tile_first[0], tile_last[0]}), 0);
    chk({nm, "_row_col"}, int'({tr0, tc0}), 0);
    chk({nm, "_busy"}, int'(busy[0]), 0);
    chk({nm, "_done"}, int'(done[0]), 0);
  endtask

  initial begin
    int i;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; out_ready[d] = 1'b1; tile_done[d] = 1'b0;
      rnd[d] = 1'b0; td_cnt[d] = 0; prev_stall[d] = 1'b0;
    end
    clear_counts();
    build(0);
    build(1);

    chk("model_a0", tab[0][0].a, 0);
    chk("model_a1", tab[0][1].a, 16);
    chk("model_a4", tab[0][4].a, 1);
    chk("model_b0", tab[0][0].b, 0);
    chk("model_b1", tab[0][1].b, 1);
    chk("model_b4", tab[0][4].b, 12);
    chk("model_t01_b", tab[0][64].b, 4);
    chk("model_t10_a", tab[0][192].a, 64);
    chk("model_last_a", tab[0][575].a, 191);
    chk("model_last_b", tab[0][575].b, 191);
    chk("model_len0", len[0], 576);
    chk("model_rag_ap", tab[1][34].ap, 1);
    chk("model_rag_a", tab[1][34].a, 0);
    chk("model_rag_bp", tab[1][19].bp, 1);
    chk("model_len1", len[1], 64);

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Both instances, full throughput.
    clear_counts();
    start[0] = 1'b1;
    start[1] = 1'b1;
    tick();
    run_to_idle("pass_full", 3000);
    chk("full_beats", beats[0], 576);
    chk("full_dones", dones[0], 1);
    chk("full_a_pads", n_ap[0], 0);
    chk("full_b_pads", n_bp[0], 0);
    chk("rag_beats", beats[1], 64);
    chk("rag_dones", dones[1], 1);
    chk("rag_a_pads", n_ap[1], 16);
    chk("rag_b_pads", n_bp[1], 16);
    chk("rag_both_pads", n_both[1], 8);

    // Random backpressure plus ignored start/tile_done during streaming.
    clear_counts();
    rnd[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    i = 0;
    while (ph[0] != P_IDLE && i < 6000) begin
      if (i == 10) tile_done[0] = 1'b1;
      if (i == 15) start[0] = 1'b1;
      tick();
      i++;
    end
    if (i >= 6000) chk("stall_timeout", 1, 0);
    rnd[0] = 1'b0;
    chk("stall_beats", beats[0], 576);
    chk("stall_dones", dones[0], 1);

    // Abort in tile (1,1) at beat 20, then a fresh replay.
    clear_counts();
    start[0] = 1'b1;
    tick();
    i = 0;
    while (ptr[0] != 276 && i < 1000) begin
      tick();
      i++;
    end
    if (i >= 1000) chk("abort_timeout", 1, 0);
    chk("abort_pre_row", int'(tr0), 1);
    chk("abort_pre_col", int'(tc0), 1);
    abort[0] = 1'b1;
    tick();
    chk("abort_valid", int'(out_valid[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    repeat (4) tick();
    chk("abort_no_done", dones[0], 0);
    start[0] = 1'b1;
    tick();
    chk("replay_valid", int'(out_valid[0]), 1);
    chk("replay_a0", int'(a_addr[0]), 0);
    run_to_idle("replay", 3000);
    chk("replay_beats", beats[0], 276 + 576);
    chk("replay_dones", dones[0], 1);

    // Asynchronous reset while waiting for a tile to drain.
    clear_counts();
    start[0] = 1'b1;
    tick();
    i = 0;
    while (ph[0] != P_WAIT && i < 300) begin
      tick();
      i++;
    end
    if (i >= 300) chk("wait_timeout", 1, 0);
    chk("wait_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    td_cnt[0] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("post_rst_busy", int'(busy[0]), 0);
    end
    chk("post_rst_no_done", dones[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_operand_sequencer.md
Name: tile_operand_sequencer

Overview:
Synthesisable operand address generator for the tiled systolic array. Walks an M_SIZE×K_SIZE matrix A and a K_SIZE×N_SIZE matrix B, both row-major, in output-tile order. Streams one lockstep A/B address beat per handshake to the operand memories. Replaces the fixed testbench-side A/B address counters and pre-replicated B image with general M/N/K, ragged-edge zero padding and per-tile flow control. Sits between the top-level controller and the operand SRAMs feeding the array edges.

Parameters:
M_SIZE, 12, rows of A / C
N_SIZE, 12, columns of B / C
K_SIZE, 16, shared inner dimension
TILE, 4, array edge (HEIGHT = WIDTH = TILE)
ADDR_WIDTH, 16, operand address width; must hold max(M_SIZE*K_SIZE, K_SIZE*N_SIZE)-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a full matrix pass
abort  in  1  synchronous cancel
out_ready  in  1  consumer accepts the current beat
tile_done  in  1  array finished the current tile; results drained
a_addr  out  ADDR_WIDTH  A element address
b_addr  out  ADDR_WIDTH  B element address
a_pad  out  1  A element lies outside M; consumer substitutes 0
b_pad  out  1  B element lies outside N; consumer substitutes 0
out_valid  out  1  beat valid
tile_first  out  1  current beat is the first beat of a tile
tile_last  out  1  current beat is the last beat of a tile
tile_row  out  $clog2(TM)+1  tile row index tm
tile_col  out  $clog2(TN)+1  tile column index tn
busy  out  1  not IDLE
done  out  1  one-cycle pulse after the last tile completes

Behaviour:
- Derived constants: TM = ceil(M_SIZE/TILE), TN = ceil(N_SIZE/TILE), BEATS = K_SIZE*TILE.
- Counters:
  - r: 0..TILE-1, innermost.
  - k: 0..K_SIZE-1.
  - tn: 0..TN-1.
  - tm: 0..TM-1, outermost.
  - Tile order is row-major: tn increments first, then tm.
- Beat (tm, tn, k, r):
  - row = tm*TILE + r; col = tn*TILE + r.
  - a_addr = row*K_SIZE + k; b_addr = k*N_SIZE + col.
  - If row >= M_SIZE: a_pad = 1 and a_addr = 0. If col >= N_SIZE: b_pad = 1 and b_addr = 0.
- FSM states: IDLE, STREAM, WAIT_TILE, FINISH.
  - IDLE: start → STREAM; clear all counters.
  - STREAM: out_valid = 1. On out_valid & out_ready, advance r, then k. The beat with k = K_SIZE-1 and r = TILE-1 asserts tile_last; accepting it → WAIT_TILE.
  - WAIT_TILE: out_valid = 0. On tile_done:
    - if tm = TM-1 and tn = TN-1 → FINISH;
    - else advance tn (wrap to 0 and increment tm), clear k and r → STREAM.
  - FINISH: done = 1 for exactly one cycle → IDLE.
- Backpressure: while out_valid & !out_ready, all outputs hold stable. There are no bubbles when out_ready stays high (1 beat/cycle).
- tile_first = 1 on the beat with k = 0 and r = 0 while in STREAM.
- tile_done in STREAM or IDLE is ignored. tile_done in the same cycle as the tile_last acceptance is ignored; the block must see it in WAIT_TILE.
- start while busy is ignored.
- abort (any state) → IDLE next cycle: out_valid = 0, done is not pulsed, counters cleared. abort has priority over start, tile_done and the handshake.
- Reset values:
  - out_valid, tile_first, tile_last, busy, done, a_pad, b_pad = 0.
  - a_addr, b_addr, tile_row, tile_col = 0.
  - State = IDLE.
  - Asynchronous reset mid-pass behaves as abort, applied immediately.
- Address arithmetic is unsigned at ADDR_WIDTH. Implement it with running base registers updated by +K_SIZE / +N_SIZE / +1 / +TILE steps, not multipliers.
- Elaboration checks: TILE >= 1, K_SIZE >= 1, and ADDR_WIDTH is sufficient.

Decomposition:
- Shared package systolic_pkg:
  - function clog2_ceil_div(a, b) for TM/TN;
  - seq_state_t enum (IDLE, STREAM, WAIT_TILE, FINISH);
  - TILE default constant shared with the array top.
- One natural sub-module: tile_index_counter, a nested r/k/tn/tm counter with wrap flags and running bases. The FSM and handshake stay in the top module.

Test Plan:
- Defaults (12,12,16,4), out_ready = 1, tile_done 3 cycles after each tile_last:
  - Tile (0,0): beats 0/1/4 give a_addr 0/16/1 and b_addr 0/1/12.
  - Tile (0,1): first b_addr = 4.
  - Tile (1,0): first a_addr = 64.
  - Tile (2,2): last beat a_addr = 191, b_addr = 191.
  - Totals: 9 tiles × 64 beats, one done pulse, no pads.
- Ragged M=N=6, K=4, TILE=4: TM = TN = 2.
  - Tile (1,0), r=2 → a_pad = 1, a_addr = 0.
  - Tile (0,1), r=3 → b_pad = 1.
  - Tile (1,1): all r >= 2 beats pad on both operands.
- Random out_ready (50%): every beat held stable while stalled; beat sequence is identical to the no-stall run; beat count is 576.
- abort asserted mid-tile (1,1), beat 20: out_valid = 0 and busy = 0 next cycle, no done pulse. A fresh start then replays from a_addr = 0.
- start pulsed while busy and tile_done pulsed during STREAM: both ignored; tile order and beat count unchanged.
- rst_n asserted during WAIT_TILE: all outputs 0 asynchronously. After release, busy stays 0 until start.
